e_mdu_unit: RTL and testbench
=============================

Name: e_mdu_unit

Overview:
Execute-stage multiply/divide unit. It consumes the operand and instruction-class outputs of the decode-to-execute pipeline register: rs data, rt data, and the decoded MDU op. It models the multi-cycle latency of mult/div and owns the architectural HI/LO registers. It exports a stall request that the hazard unit uses to hold the decode-to-execute register (enable low) and bubble the pipeline.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
op_valid  input  1  1 = op_E describes a real instruction; 0 = bubble or flushed slot
op_E  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none
rs_E  input  32  forwarded rs operand (dividend / multiplicand / mthi/mtlo source)
rt_E  input  32  forwarded rt operand (divisor / multiplier)
busy  output  1  registered; 1 while a mult/div is in flight
start  output  1  combinational; op_valid & op_E in {1..4} & ~busy
mdu_stall  output  1  combinational; busy | start; the hazard unit stalls any MDU-class instruction in decode when this is 1
rd_data  output  32  combinational; HI for mfhi, LO for mflo, 0 otherwise
hi  output  32  architectural HI (registered)
lo  output  32  architectural LO (registered)

Behaviour:
- Reset: busy=0, internal counter=0, hi=0, lo=0, pending result registers=0. Reset overrides every other input in that cycle. A reset during an operation aborts it; the result is discarded.
- Accepted op: op_valid=1 and ~busy at the edge. While busy=1, every op, including mthi/mtlo/mfhi/mflo, is ignored with no state change. The hazard unit guarantees none arrive; the bench checks that they are ignored anyway.
- mult (signed) / multu (unsigned): full 64-bit product. {hi_pend, lo_pend} = product. Counter loads MULT_CYCLES.
- div (signed):
  - lo_pend = quotient, truncated toward zero.
  - hi_pend = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo_pend=0x80000000, hi_pend=0.
- divu: unsigned quotient and remainder.
- Divisor 0 (div or divu): the unit still goes busy for DIV_CYCLES. On completion HI/LO are left unchanged.
- Timing: start sampled at edge ending cycle T.
  - busy=1 in cycles T+1 .. T+N (N = MULT_CYCLES or DIV_CYCLES). The counter decrements each cycle.
  - At the edge where the counter goes 1 -> 0, hi/lo take the pending values and busy falls.
  - New hi/lo are visible from cycle T+N+1.
- mthi: hi <= rs_E at the accepting edge, 1-cycle latency. mtlo: same for lo. No busy is raised.
- mfhi/mflo: rd_data is combinational from the current hi/lo. No state change.
- Simultaneous completion and new op: impossible, because busy=1 on the completion cycle blocks acceptance. The next op is accepted in cycle T+N+1 at the earliest.
- op_valid=0: no state change regardless of op_E. Flushed slots never start or modify HI/LO.
- The counter is wide enough for max(MULT_CYCLES, DIV_CYCLES) and has no wrap-around. The counter only loads when it is 0.

Test Plan:
1. Reset, then mult rs=0xFFFFFFFF rt=0x00000002 (signed) -> mdu_stall=1 in the issue cycle; busy=1 for exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE.
2. multu rs=0xFFFFFFFF rt=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. An mfhi in the next cycle gives rd_data=0x00000001.
3. div rs=0xFFFFFFF9 (-7) rt=0x00000002 -> busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). The same operands with divu give lo=0x7FFFFFFC, hi=0x00000001.
4. mthi 0x12345678, then div rs=5 rt=0 -> busy 10 cycles; hi stays 0x12345678 and lo stays at its prior value. Also check div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Start mult, and in busy cycle 2 drive mtlo 0xDEAD with op_valid=1 -> ignored; lo equals the product low word after completion. A mult presented with op_valid=0 -> start=0, busy never rises.
6. Start div, assert reset in busy cycle 4 -> next cycle busy=0, hi=lo=0. A mult issued after reset completes normally in 5 cycles.

Source files
------------

// File: rtl/e_mdu_unit.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div latency model,
// architectural HI/LO registers and the MDU stall request for the hazard unit.
module e_mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [3:0]  op_E,
   input  logic [31:0] rs_E,
   input  logic [31:0] rt_E,
   output logic        busy,
   output logic        start,
   output logic        mdu_stall,
   output logic [31:0] rd_data,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   // state  | meaning
   // S_IDLE | no operation in flight; ops are accepted
   // S_BUSY | mult/div in flight; counter runs down, all ops ignored

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
   logic          wr_q, wr_d;

   logic          accept;
   logic [63:0]   prod_s, prod_u;
   logic          div_signed;
   logic [31:0]   a_mag, b_mag, num, den, den_safe, q_raw, r_raw, quot, rem;

   assign prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
   assign prod_u = {32'd0, rs_E} * {32'd0, rt_E};

   // Signed division is done on magnitudes, then signs are restored; this makes
   // 0x80000000 / -1 fall out naturally as 0x80000000 remainder 0.
   assign div_signed = (op_E == OP_DIV);
   assign a_mag      = rs_E[31] ? (~rs_E + 32'd1) : rs_E;
   assign b_mag      = rt_E[31] ? (~rt_E + 32'd1) : rt_E;
   assign num        = div_signed ? a_mag : rs_E;
   assign den        = div_signed ? b_mag : rt_E;
   assign den_safe   = (den == 32'd0) ? 32'd1 : den;
   assign q_raw      = num / den_safe;
   assign r_raw      = num % den_safe;
   assign quot       = (div_signed && (rs_E[31] ^ rt_E[31])) ? (~q_raw + 32'd1) : q_raw;
   assign rem        = (div_signed && rs_E[31]) ? (~r_raw + 32'd1) : r_raw;

   assign busy      = (state_q == S_BUSY);
   assign accept    = op_valid & ~busy;
   assign start     = accept & (op_E >= OP_MULT) & (op_E <= OP_DIVU);
   assign mdu_stall = busy | start;
   assign hi        = hi_q;
   assign lo        = lo_q;

   always_comb begin
      rd_data = 32'd0;
      if (op_E == OP_MFHI)
         rd_data = hi_q;
      else if (op_E == OP_MFLO)
         rd_data = lo_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         hi_pend_q <= 32'd0;
         lo_pend_q <= 32'd0;
         wr_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         hi_pend_q <= hi_pend_d;
         lo_pend_q <= lo_pend_d;
         wr_q      <= wr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      hi_pend_d = hi_pend_q;
      lo_pend_d = lo_pend_q;
      wr_d      = wr_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op_E)
                  OP_MULT: begin
                     hi_pend_d = prod_s[63:32];
                     lo_pend_d = prod_s[31:0];
                     wr_d      = 1'b1;
                     cnt_d     = MULT_LOAD;
                     state_d   = S_BUSY;
                  end
                  OP_MULTU: begin
                     hi_pend_d = prod_u[63:32];
                     lo_pend_d = prod_u[31:0];
                     wr_d      = 1'b1;
                     cnt_d     = MULT_LOAD;
                     state_d   = S_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     hi_pend_d = rem;
                     lo_pend_d = quot;
                     wr_d      = (rt_E != 32'd0);
                     cnt_d     = DIV_LOAD;
                     state_d   = S_BUSY;
                  end
                  OP_MTHI: hi_d = rs_E;
                  OP_MTLO: lo_d = rs_E;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               // A zero divisor runs the full latency but leaves HI/LO alone.
               if (wr_q) begin
                  hi_d = hi_pend_q;
                  lo_d = lo_pend_q;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_e_mdu_unit.sv
// Randomized scoreboard bench for e_mdu_unit: expected HI/LO and busy length
// are queued at issue and checked by a monitor when busy falls.
module tb_e_mdu_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [3:0]  op_E;
   logic [31:0] rs_E, rt_E;
   logic        busy, start, mdu_stall;
   logic [31:0] rd_data, hi, lo;

   e_mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_E(op_E),
      .rs_E(rs_E), .rt_E(rt_E), .busy(busy), .start(start),
      .mdu_stall(mdu_stall), .rd_data(rd_data), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   exp_t        scb[$];
   int          vectors = 0;
   int          errors  = 0;
   logic [31:0] mhi = 32'd0;
   logic [31:0] mlo = 32'd0;
   logic        rst_at_edge = 1'b1;
   logic        busy_prev = 1'b0;
   int          busy_cnt = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(posedge clk) rst_at_edge <= reset;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_at_edge)
         busy_cnt = 0;
      else if (busy === 1'b1)
         busy_cnt++;
      else if (busy_prev) begin
         if (scb.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_completion: got busy fall expected none");
         end else begin
            e = scb.pop_front();
            check("busy_len", 32'(busy_cnt), 32'(e.n));
            check("hi_commit", hi, e.hi);
            check("lo_commit", lo, e.lo);
         end
         busy_cnt = 0;
      end
      busy_prev = (busy === 1'b1);
   end

   task automatic drive(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic v);
      @(posedge clk);
      #1;
      op_E = op; rs_E = a; rt_E = b; op_valid = v;
   endtask

   // Issue one op while the unit is idle and update the architectural model.
   task automatic issue_op(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic v);
      logic        exp_start;
      exp_t        e;
      longint      sp;
      logic [63:0] up;
      int          sa, sd, q, r;
      drive(op, a, b, v);
      #1;
      exp_start = v && (op >= 4'd1) && (op <= 4'd4);
      check("start", 32'(start), 32'(exp_start));
      check("mdu_stall", 32'(mdu_stall), 32'(exp_start));
      if (v) check("rd_data", rd_data, (op == 4'd5) ? mhi : (op == 4'd6) ? mlo : 32'd0);
      if (v) begin
         e.hi = mhi; e.lo = mlo;
         case (op)
            4'd1: begin
               sp = longint'(int'(a)) * longint'(int'(b));
               e.hi = sp[63:32]; e.lo = sp[31:0]; e.n = MC;
            end
            4'd2: begin
               up = 64'(a) * 64'(b);
               e.hi = up[63:32]; e.lo = up[31:0]; e.n = MC;
            end
            4'd3: begin
               sa = int'(a); sd = int'(b); e.n = DC;
               if (sd != 0) begin
                  if (sa == int'(32'h8000_0000) && sd == -1) begin
                     q = sa; r = 0;
                  end else begin
                     q = sa / sd; r = sa % sd;
                  end
                  e.hi = r; e.lo = q;
               end
            end
            4'd4: begin
               e.n = DC;
               if (b != 32'd0) begin
                  e.hi = a % b; e.lo = a / b;
               end
            end
            4'd7: mhi = a;
            4'd8: mlo = a;
            default: ;
         endcase
         if (op >= 4'd1 && op <= 4'd4) begin
            mhi = e.hi; mlo = e.lo;
            scb.push_back(e);
         end
      end
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         drive(4'd0, 32'd0, 32'd0, 1'b0);
         #1;
         if (busy === 1'b0) done = 1'b1;
      end
      if (!done) begin
         vectors++;
         errors++;
         $display("FAIL wait_idle: got busy stuck expected idle");
      end
      #5;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] lo_prev, a, b;
      logic [3:0]  op;
      logic        v;
      reset = 1'b1; op_valid = 1'b0; op_E = 4'd0; rs_E = 32'd0; rt_E = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_start", 32'(start), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      issue_op(4'd1, 32'hFFFF_FFFF, 32'h2, 1'b1);
      wait_idle();
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFE);

      issue_op(4'd2, 32'hFFFF_FFFF, 32'h2, 1'b1);
      wait_idle();
      issue_op(4'd5, 32'd0, 32'd0, 1'b1);
      check("mfhi_multu", rd_data, 32'h0000_0001);
      check("multu_lo", lo, 32'hFFFF_FFFE);
      wait_idle();

      issue_op(4'd3, 32'hFFFF_FFF9, 32'h2, 1'b1);
      wait_idle();
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);
      issue_op(4'd4, 32'hFFFF_FFF9, 32'h2, 1'b1);
      wait_idle();
      check("divu_lo", lo, 32'h7FFF_FFFC);
      check("divu_hi", hi, 32'h0000_0001);

      issue_op(4'd7, 32'h1234_5678, 32'd0, 1'b1);
      wait_idle();
      check("mthi", hi, 32'h1234_5678);
      lo_prev = lo;
      issue_op(4'd3, 32'd5, 32'd0, 1'b1);
      wait_idle();
      check("div0_hi", hi, 32'h1234_5678);
      check("div0_lo", lo, lo_prev);
      issue_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_idle();
      check("divovf_lo", lo, 32'h8000_0000);
      check("divovf_hi", hi, 32'd0);

      issue_op(4'd1, 32'h0000_1234, 32'h0000_0100, 1'b1);
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      drive(4'd8, 32'h0000_DEAD, 32'd0, 1'b1);
      #1;
      check("busy_start", 32'(start), 32'd0);
      check("busy_stall", 32'(mdu_stall), 32'd1);
      wait_idle();
      check("mtlo_ignored", lo, 32'h0012_3400);
      issue_op(4'd1, 32'd3, 32'd4, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(4'd0, 32'd0, 32'd0, 1'b0);
         #1;
         check("flushed_busy", 32'(busy), 32'd0);
      end

      issue_op(4'd3, 32'd100, 32'd7, 1'b1);
      repeat (3) drive(4'd0, 32'd0, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      scb.delete();
      mhi = 32'd0; mlo = 32'd0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      issue_op(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b1);
      wait_idle();
      check("post_rst_lo", lo, 32'hFFFF_FFEB);

      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 9));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         v = ($urandom_range(0, 7) != 0);
         issue_op(op, a, b, v);
         wait_idle();
         check("rand_hi", hi, mhi);
         check("rand_lo", lo, mlo);
      end

      check("scb_drained", 32'(scb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
